alu_op_scheduler: RTL and testbench
===================================

// Module: alu_op_scheduler
// PURPOSE
//  Shares one alu_db instance between two requesters (req0, req1). Picks one pending op by
//  round-robin, drives the ALU inputs, waits a fixed settle time, then returns the chosen ALU
//  result on a valid/ready response channel. Sits between the host-side op queues and alu_db.
// PARAMETERS
//  WAIT_CYC   2   cycles from accept to result capture; >=2 (alu_db Storing is a clocked flop)
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous reset, active low
//  reqN_valid    in   1   N=0,1: op pending from requester N
//  reqN_ready    out  1   N=0,1: op accepted this cycle (valid&ready)
//  reqN_op       in   4   N=0,1: result select (table below)
//  reqN_opnd     in   10  N=0,1: {A,B,C,D,S1,S0,M1[1:0],M2[1:0]}
//  alu_a..alu_d  out  1   ALU data inputs A,B,C,D
//  alu_s0,alu_s1 out  1   ALU mux selects
//  alu_m1,alu_m2 out  2   ALU multiplier operands
//  alu_flags     in   13  {NOR,NAND,XNOR,XOR,NOT,OR,AND,Mux_out,Storing,Bout,Diff,Carry,Sum}
//  alu_product   in   4   ALU Product
//  alu_decoder   in   4   ALU Decoder_Y
//  rsp_valid     out  1   response available
//  rsp_ready     in   1   consumer accepts response
//  rsp_id        out  1   requester that owns the response
//  rsp_data      out  4   result, single-bit results zero-extended
//  rsp_err       out  1   op code illegal
//  op_count      out  16  completed-response count (see CONFIGURATION)
// BEHAVIOUR
//  - Op table: 0..12 = alu_flags[op] (0 Sum..12 NOR); 13 Product; 14 Decoder_Y; 15 illegal.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE. Reset state IDLE.
//  - IDLE: reqN_ready = grantN (combinational). Grant rules: only one valid -> it wins.
//    Both valid -> the requester not granted last wins. last_grant resets to 1, so req0
//    wins the first tie. reqN_ready is 0 outside IDLE.
//  - Accept edge T0: latch opnd into alu_* regs, latch op and id, load cnt=WAIT_CYC-1, go WAIT.
//    For op 15: alu_* unchanged, go straight to RESP with rsp_err=1 and rsp_data=0.
//  - WAIT: cnt decrements each cycle. At the edge where cnt==0, capture the selected result
//    into rsp_data and go RESP. rsp_valid rises WAIT_CYC cycles after T0.
//  - RESP: rsp_valid=1. rsp_id/data/err stay stable until rsp_valid&rsp_ready. On that edge
//    go IDLE and drop rsp_valid. No new accept in the same cycle. Min op period is
//    WAIT_CYC+2 cycles.
//  - alu_* hold their last issued operands between ops. The ALU is never driven mid-op.
//  - Reset (any state, async): alu_*=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0,
//    reqN_ready=0, cnt=0, last_grant=1, op_count=0. An in-flight op is dropped with no response.
//  - reqN_valid deasserting before accept is legal. reqN_opnd is sampled only at accept.
// CONFIGURATION
//  ALU_SCHED_PERF_EN defined: op_count increments on every rsp_valid&rsp_ready, illegal ops
//   included, and saturates at 16'hFFFF.
//  Not defined: op_count tied to 16'h0000 and no counter logic is built.
// TESTING
//  1 req0 op=0 opnd={1,0,1,0,0,0,00,00}, rsp_ready=1 -> req0_ready 1 cycle, alu_a=1 alu_c=1,
//    rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=Sum of alu_db (4'b0000).
//  2 req0 and req1 valid together, op=13, M1=01 and M2=10 -> req0 served first with
//    rsp_data=4'b0010, then req1. Repeat the tie: req0 wins again, since last grant was req1.
//  3 req1 op=15 -> accepted, rsp_valid on the next cycle, rsp_err=1, rsp_data=0,
//    alu_* unchanged.
//  4 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, reqN_ready=0, no new accept.
//    Release -> IDLE next cycle.
//  5 rst_n low during WAIT -> all outputs zero immediately. After release, req0 wins the
//    first tie and no stale response appears.
//  6 With ALU_SCHED_PERF_EN: 3 completed ops -> op_count=3. Preload near 16'hFFFF ->
//    saturates. Without the macro: op_count=0 always.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one alu_db between two requesters, with a valid/ready response.
// Define ALU_SCHED_PERF_EN to build the saturating completed-response counter on op_count.
module alu_op_scheduler #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [9:0]  req0_opnd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [9:0]  req1_opnd,
  output logic        alu_a,
  output logic        alu_b,
  output logic        alu_c,
  output logic        alu_d,
  output logic        alu_s0,
  output logic        alu_s1,
  output logic [1:0]  alu_m1,
  output logic [1:0]  alu_m2,
  input  logic [12:0] alu_flags,
  input  logic [3:0]  alu_product,
  input  logic [3:0]  alu_decoder,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [3:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned OPND_W = 10;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = $clog2(WAIT_CYC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [OP_W-1:0] OP_LAST_FLAG = 4'd12;
  localparam logic [OP_W-1:0] OP_PRODUCT   = 4'd13;
  localparam logic [OP_W-1:0] OP_DECODER   = 4'd14;
  localparam logic [OP_W-1:0] OP_ILLEGAL   = 4'd15;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              id_q, id_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              idle_c;
  logic              grant0_c;
  logic              grant1_c;
  logic              accept_c;
  logic [OP_W-1:0]   sel_op_c;
  logic [OPND_W-1:0] sel_opnd_c;
  logic [DATA_W-1:0] result_c;

  // Round-robin grant: on a tie the requester not served last wins.
  assign idle_c     = (state_q == S_IDLE) && rst_n;
  assign grant0_c   = idle_c && req0_valid && (!req1_valid || last_grant_q);
  assign grant1_c   = idle_c && req1_valid && (!req0_valid || !last_grant_q);
  assign accept_c   = grant0_c || grant1_c;
  assign sel_op_c   = grant1_c ? req1_op : req0_op;
  assign sel_opnd_c = grant1_c ? req1_opnd : req0_opnd;

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  // Result select from the settled ALU outputs; single-bit flags zero-extended.
  always_comb begin
    result_c = '0;
    if (op_q <= OP_LAST_FLAG) begin
      result_c = {3'b000, alu_flags[op_q]};
    end else if (op_q == OP_PRODUCT) begin
      result_c = alu_product;
    end else if (op_q == OP_DECODER) begin
      result_c = alu_decoder;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    id_d         = id_q;
    opnd_d       = opnd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          last_grant_d = grant1_c;
          id_d         = grant1_c;
          op_d         = sel_op_c;
          // Illegal ops never touch the ALU and answer immediately.
          if (sel_op_c == OP_ILLEGAL) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant1_c;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            opnd_d  = sel_opnd_c;
            cnt_d   = CNT_W'(WAIT_CYC - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = result_c;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      id_q         <= 1'b0;
      opnd_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      id_q         <= id_d;
      opnd_q       <= opnd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign {alu_a, alu_b, alu_c, alu_d, alu_s1, alu_s0, alu_m1, alu_m2} = opnd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU_SCHED_PERF_EN
  logic [15:0] op_count_q;

  // Counts every accepted response, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_valid_q && rsp_ready && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: alu_db behavioural model, response scoreboard,
// table-driven op vectors and hand sequences for stall, illegal op, reset and op_count.
module tb_alu_op_scheduler;

  localparam int unsigned BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [9:0]  req0_opnd = '0, req1_opnd = '0;
  logic        alu_a, alu_b, alu_c, alu_d, alu_s0, alu_s1;
  logic [1:0]  alu_m1, alu_m2;
  logic [12:0] alu_flags;
  logic [3:0]  alu_product, alu_decoder;
  logic        rsp_valid, rsp_id, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [3:0]  rsp_data;
  logic [15:0] op_count;

  alu_op_scheduler #(.WAIT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_opnd(req0_opnd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_opnd(req1_opnd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d), .alu_s0(alu_s0), .alu_s1(alu_s1),
    .alu_m1(alu_m1), .alu_m2(alu_m2), .alu_flags(alu_flags), .alu_product(alu_product),
    .alu_decoder(alu_decoder), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // alu_db model: combinational gates/adders plus a clocked Storing flop on D.
  logic       store_q = 1'b0;
  logic [3:0] mux_in;
  always @(posedge clk) store_q <= alu_d;
  assign mux_in = {alu_d, alu_c, alu_b, alu_a};
  assign alu_flags = {~(alu_a | alu_b), ~(alu_a & alu_b), ~(alu_a ^ alu_b), alu_a ^ alu_b,
                      ~alu_a, alu_a | alu_b, alu_a & alu_b, mux_in[{alu_s1, alu_s0}], store_q,
                      (~alu_a & alu_b) | (~(alu_a ^ alu_b) & alu_c), alu_a ^ alu_b ^ alu_c,
                      (alu_a & alu_b) | (alu_c & (alu_a ^ alu_b)), alu_a ^ alu_b ^ alu_c};
  assign alu_product = 4'(alu_m1) * 4'(alu_m2);
  assign alu_decoder = 4'(4'd1 << {alu_s1, alu_s0});

  typedef struct packed { logic id; logic [3:0] data; logic err; } rsp_t;
  typedef struct {
    logic v0, v1; logic [3:0] op0; logic [9:0] o0; logic [3:0] op1; logic [9:0] o1;
    logic exp_id; logic [3:0] exp_data;
  } vec_t;

  rsp_t       sb_q[$];
  rsp_t       seen_q[$];
  vec_t       vecs[11];
  logic [9:0] last_opnd = '0;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
  endtask

  function automatic logic [3:0] ref_result(input logic [3:0] op, input logic [9:0] o);
    logic a, b, c, d;
    logic [1:0] s, m1, m2;
    logic [3:0] mx;
    {a, b, c, d, s, m1, m2} = o;
    mx = {d, c, b, a};
    case (op)
      4'd0:  return {3'b000, a ^ b ^ c};
      4'd1:  return {3'b000, (a & b) | (c & (a ^ b))};
      4'd2:  return {3'b000, a ^ b ^ c};
      4'd3:  return {3'b000, (~a & b) | (~(a ^ b) & c)};
      4'd4:  return {3'b000, d};
      4'd5:  return {3'b000, mx[s]};
      4'd6:  return {3'b000, a & b};
      4'd7:  return {3'b000, a | b};
      4'd8:  return {3'b000, ~a};
      4'd9:  return {3'b000, a ^ b};
      4'd10: return {3'b000, ~(a ^ b)};
      4'd11: return {3'b000, ~(a & b)};
      4'd12: return {3'b000, ~(a | b)};
      4'd13: return 4'(m1) * 4'(m2);
      4'd14: return 4'(4'd1 << s);
      default: return 4'd0;
    endcase
  endfunction

  task automatic push(input logic id, input logic [3:0] op, input logic [9:0] o);
    if (op == 4'd15) begin
      sb_q.push_back('{id: id, data: 4'd0, err: 1'b1});
    end else begin
      sb_q.push_back('{id: id, data: ref_result(op, o), err: 1'b0});
      last_opnd = o;
    end
  endtask

  // Response checker: compares each handshaken response against the scoreboard head.
  always @(negedge clk) begin : rsp_chk
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("stale_rsp_valid", 16'(rsp_valid), 16'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_id", 16'(rsp_id), 16'(e.id));
        check("rsp_data", 16'(rsp_data), 16'(e.data));
        check("rsp_err", 16'(rsp_err), 16'(e.err));
        seen_q.push_back('{id: rsp_id, data: rsp_data, err: rsp_err});
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < BUDGET) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (sb_q.size() != 0) timeout("drain");
  endtask

  task automatic issue(input logic v0, input logic v1, input logic [3:0] op0, input logic [9:0] o0,
                       input logic [3:0] op1, input logic [9:0] o1);
    int k = 0;
    logic a0, a1;
    req0_valid = v0; req0_op = op0; req0_opnd = o0;
    req1_valid = v1; req1_op = op1; req1_opnd = o1;
    while ((req0_valid || req1_valid) && k < BUDGET) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) push(1'b0, op0, o0);
      if (a1) push(1'b1, op1, o1);
      @(posedge clk);
      #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      k++;
    end
    if (req0_valid || req1_valid) begin
      timeout("accept");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    drain();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
    check({tag, "_rsp_id"}, 16'(rsp_id), 16'd0);
    check({tag, "_rsp_data"}, 16'(rsp_data), 16'd0);
    check({tag, "_rsp_err"}, 16'(rsp_err), 16'd0);
    check({tag, "_alu"}, 16'({alu_a, alu_b, alu_c, alu_d, alu_s1, alu_s0, alu_m1, alu_m2}), 16'd0);
    check({tag, "_op_count"}, op_count, 16'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 4'd13, 10'h006, 4'd13, 10'h00F, 1'b0, 4'd2};
    vecs[1]  = '{1'b1, 1'b1, 4'd13, 10'h006, 4'd13, 10'h00F, 1'b0, 4'd2};
    vecs[2]  = '{1'b1, 1'b0, 4'd0,  10'h280, 4'd0,  10'h000, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 1'b1, 4'd0,  10'h000, 4'd12, 10'h000, 1'b1, 4'd1};
    vecs[4]  = '{1'b1, 1'b0, 4'd5,  10'h070, 4'd0,  10'h000, 1'b0, 4'd1};
    vecs[5]  = '{1'b0, 1'b1, 4'd0,  10'h000, 4'd4,  10'h040, 1'b1, 4'd1};
    vecs[6]  = '{1'b1, 1'b0, 4'd14, 10'h020, 4'd0,  10'h000, 1'b0, 4'd4};
    vecs[7]  = '{1'b0, 1'b1, 4'd0,  10'h000, 4'd1,  10'h300, 1'b1, 4'd1};
    vecs[8]  = '{1'b1, 1'b1, 4'd2,  10'h280, 4'd11, 10'h280, 1'b0, 4'd0};
    vecs[9]  = '{1'b1, 1'b0, 4'd6,  10'h300, 4'd0,  10'h000, 1'b0, 4'd1};
    vecs[10] = '{1'b1, 1'b1, 4'd7,  10'h000, 4'd9,  10'h200, 1'b1, 4'd1};

    // Reset values, including ready held low while both requesters are pending.
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req0_ready", 16'(req0_ready), 16'd0);
    check("reset_req1_ready", 16'(req1_ready), 16'd0);
    check_zero_outputs("reset");
    do_reset();

    // Single op latency: ready for one cycle, response two cycles after accept.
    req0_valid = 1'b1; req0_op = 4'd0; req0_opnd = 10'h280;
    @(negedge clk);
    check("lat_req0_ready", 16'(req0_ready), 16'd1);
    push(1'b0, 4'd0, 10'h280);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    check("lat_alu_operands", 16'({alu_a, alu_b, alu_c, alu_d, alu_s1, alu_s0, alu_m1, alu_m2}), 16'h280);
    check("lat_rsp_valid_t1", 16'(rsp_valid), 16'd0);
    @(posedge clk);
    #1;
    check("lat_rsp_valid_t2", 16'(rsp_valid), 16'd0);
    @(posedge clk);
    #1;
    check("lat_rsp_valid_t3", 16'(rsp_valid), 16'd1);
    check("lat_rsp_id", 16'(rsp_id), 16'd0);
    check("lat_rsp_data", 16'(rsp_data), 16'd0);
    drain();

    // Table-driven op vectors from a fresh reset so the first tie goes to req0.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      seen_q.delete();
      issue(vecs[i].v0, vecs[i].v1, vecs[i].op0, vecs[i].o0, vecs[i].op1, vecs[i].o1);
      if (seen_q.size() != 0) begin
        check($sformatf("vec%0d_first_id", i), 16'(seen_q[0].id), 16'(vecs[i].exp_id));
        check($sformatf("vec%0d_first_data", i), 16'(seen_q[0].data), 16'(vecs[i].exp_data));
      end else begin
        timeout($sformatf("vec%0d_response", i));
      end
    end

    // Illegal op from req1, then a 5-cycle consumer stall with req0 pending.
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd15; req1_opnd = 10'h3FF;
    @(negedge clk);
    check("ill_req1_ready", 16'(req1_ready), 16'd1);
    push(1'b1, 4'd15, 10'h3FF);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_opnd = 10'h280;
    check("ill_rsp_valid", 16'(rsp_valid), 16'd1);
    check("ill_rsp_err", 16'(rsp_err), 16'd1);
    check("ill_rsp_data", 16'(rsp_data), 16'd0);
    check("ill_alu_unchanged", 16'({alu_a, alu_b, alu_c, alu_d, alu_s1, alu_s0, alu_m1, alu_m2}),
          16'(last_opnd));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req0_ready", 16'(req0_ready), 16'd0);
      check("stall_rsp_valid", 16'(rsp_valid), 16'd1);
      check("stall_rsp_id", 16'(rsp_id), 16'd1);
      check("stall_rsp_err", 16'(rsp_err), 16'd1);
      check("stall_rsp_data", 16'(rsp_data), 16'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_rsp_valid", 16'(rsp_valid), 16'd0);
    check("release_req0_ready", 16'(req0_ready), 16'd1);
    issue(1'b1, 1'b0, 4'd0, 10'h280, 4'd0, 10'h000);

    // Reset while an op is in WAIT: op dropped, outputs cleared, tie priority restored.
    req0_valid = 1'b1; req0_op = 4'd13; req0_opnd = 10'h3FF;
    @(negedge clk);
    check("rstw_req0_ready", 16'(req0_ready), 16'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_zero_outputs("rstw");
    check("rstw_req0_ready_low", 16'(req0_ready), 16'd0);
    check("rstw_req1_ready_low", 16'(req1_ready), 16'd0);
    do_reset();
    seen_q.delete();
    issue(1'b1, 1'b1, 4'd13, 10'h006, 4'd13, 10'h00F);
    if (seen_q.size() == 2) begin
      check("rstw_tie_first_id", 16'(seen_q[0].id), 16'd0);
      check("rstw_tie_second_id", 16'(seen_q[1].id), 16'd1);
    end else begin
      timeout("rstw_tie_responses");
    end

`ifdef ALU_SCHED_PERF_EN
    // Completed-response counter and saturation.
    do_reset();
    issue(1'b1, 1'b0, 4'd0, 10'h280, 4'd0, 10'h000);
    issue(1'b0, 1'b1, 4'd0, 10'h000, 4'd15, 10'h000);
    issue(1'b1, 1'b0, 4'd13, 10'h006, 4'd0, 10'h000);
    check("op_count_three", op_count, 16'd3);
    force dut.op_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_count_q;
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 4'd0, 10'h280, 4'd0, 10'h000);
    check("op_count_max", op_count, 16'hFFFF);
    issue(1'b1, 1'b0, 4'd0, 10'h280, 4'd0, 10'h000);
    check("op_count_saturate", op_count, 16'hFFFF);
`else
    check("op_count_tied_zero", op_count, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
